// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stage bus carrying a control bundle and a data bundle.
// master drives valid/ctrl/data, slave drives ready.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 192
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer, flush and bubble insertion.
// Optional saturating stall/bubble counters are enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 192,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  pipe_stage_reg_if.slave     up,
  pipe_stage_reg_if.master    dn,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    bubble_cnt
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t            state_p0, stateNxt;
  logic [CTRL_W-1:0] mainCtrl_p0, skidCtrl_p0;
  logic [DATA_W-1:0] mainData_p0, skidData_p0;

  logic outVld, inRdy, accept, emit;
  logic loadMainIn, loadMainSkid, loadSkid, clearCtrl;

  // in_ready comes straight from the state register, never from out_ready
  assign inRdy    = (state_p0 != SKID);
  assign outVld   = (state_p0 != EMPTY);
  assign accept   = up.valid & inRdy;
  assign emit     = outVld & dn.ready;

  assign up.ready = inRdy;
  assign dn.valid = outVld;
  assign dn.ctrl  = mainCtrl_p0;
  assign dn.data  = mainData_p0;

  always_comb begin
    stateNxt     = state_p0;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    clearCtrl    = 1'b0;
    unique case (state_p0)
      EMPTY: begin
        if (accept) begin
          stateNxt   = FULL;
          loadMainIn = 1'b1;
        end
      end
      FULL: begin
        if (accept && emit) begin
          loadMainIn = 1'b1;
        end else if (accept) begin
          stateNxt = SKID;
          loadSkid = 1'b1;
        end else if (emit) begin
          stateNxt  = EMPTY;
          clearCtrl = 1'b1;
        end
      end
      SKID: begin
        if (emit) begin
          stateNxt     = FULL;
          loadMainSkid = 1'b1;
        end
      end
      default: begin
        stateNxt  = EMPTY;
        clearCtrl = 1'b1;
      end
    endcase
    // flush discards everything held and anything moving this cycle
    if (flush) begin
      stateNxt     = EMPTY;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
      clearCtrl    = 1'b1;
    end
  end

  // Stage p0: main (output) and skid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= EMPTY;
      mainCtrl_p0 <= '0;
      mainData_p0 <= '0;
    end else begin
      state_p0 <= stateNxt;
      if (clearCtrl)         mainCtrl_p0 <= '0;
      else if (loadMainIn)   mainCtrl_p0 <= up.ctrl;
      else if (loadMainSkid) mainCtrl_p0 <= skidCtrl_p0;
      if (loadMainIn)        mainData_p0 <= up.data;
      else if (loadMainSkid) mainData_p0 <= skidData_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (loadSkid) begin
      skidCtrl_p0 <= up.ctrl;
      skidData_p0 <= up.data;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] stallCnt_p0, bubbleCnt_p0;

  // Counters survive flush; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_p0  <= '0;
      bubbleCnt_p0 <= '0;
    end else begin
      if (outVld && !dn.ready) stallCnt_p0  <= satInc(stallCnt_p0);
      if (!outVld)             bubbleCnt_p0 <= satInc(bubbleCnt_p0);
    end
  end

  assign stall_cnt  = stallCnt_p0;
  assign bubble_cnt = bubbleCnt_p0;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
